// File: rtl/maze_nav_engine.sv
// maze_nav_engine: debounced 4-button maze walker with goal detect
// and a row-scanned LED matrix view of walls and player.
module maze_nav_engine #(
  parameter int GRID_W = 8,
  parameter int GRID_H = 8,
  parameter logic [GRID_W*GRID_H-1:0] WALL_MAP = '0,
  parameter int START_X = 0,
  parameter int START_Y = GRID_H - 1,
  parameter int GOAL_X = GRID_W - 1,
  parameter int GOAL_Y = 0,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int SCAN_DIV = 1024,
  parameter int COUNT_W = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      btnTop,
  input  logic                      btnBottom,
  input  logic                      btnLeft,
  input  logic                      btnRight,
  input  logic                      restart,
  output logic [$clog2(GRID_W)-1:0] pos_x,
  output logic [$clog2(GRID_H)-1:0] pos_y,
  output logic [COUNT_W-1:0]        move_count,
  output logic                      bump,
  output logic                      win,
  output logic [GRID_H-1:0]         row,
  output logic [GRID_W-1:0]         col
);
  localparam int XW = $clog2(GRID_W);
  localparam int YW = $clog2(GRID_H);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int SW = $clog2(SCAN_DIV + 1);

  typedef enum logic {PLAY, WIN} state_e;

  logic [3:0]    btn;
  logic [3:0]    s1_q, s2_q, press_q;
  logic [CW-1:0] dcnt_q [4];

  assign btn = {btnTop, btnBottom, btnLeft, btnRight};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_q    <= '0;
      s2_q    <= '0;
      press_q <= '0;
      for (int i = 0; i < 4; i++) dcnt_q[i] <= '0;
    end else begin
      s1_q <= btn;
      s2_q <= s1_q;
      for (int i = 0; i < 4; i++) begin
        // pulse on the edge where the count lands on the threshold
        press_q[i] <= s2_q[i] &&
          (dcnt_q[i] == CW'(DEBOUNCE_CYCLES - 1));
        if (!s2_q[i])
          dcnt_q[i] <= '0;
        else if (dcnt_q[i] != CW'(DEBOUNCE_CYCLES))
          dcnt_q[i] <= dcnt_q[i] + CW'(1);
      end
    end
  end

  state_e            state_q;
  logic [XW-1:0]     pos_x_q;
  logic [YW-1:0]     pos_y_q;
  logic [COUNT_W-1:0] cnt_q;
  logic              bump_q, win_q;

  int   tx, ty;
  logic mv, blocked, at_goal;

  always_comb begin
    tx = int'(pos_x_q);
    ty = int'(pos_y_q);
    mv = 1'b1;
    if (press_q[3])      ty = ty - 1;
    else if (press_q[2]) ty = ty + 1;
    else if (press_q[1]) tx = tx - 1;
    else if (press_q[0]) tx = tx + 1;
    else                 mv = 1'b0;
    blocked = 1'b0;
    if (tx < 0 || tx >= GRID_W || ty < 0 || ty >= GRID_H)
      blocked = 1'b1;
    else
      blocked = WALL_MAP[ty*GRID_W + tx];
    at_goal = (tx == GOAL_X) && (ty == GOAL_Y);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= PLAY;
      pos_x_q <= XW'(START_X);
      pos_y_q <= YW'(START_Y);
      cnt_q   <= '0;
      bump_q  <= 1'b0;
      win_q   <= 1'b0;
    end else if (restart) begin
      state_q <= PLAY;
      pos_x_q <= XW'(START_X);
      pos_y_q <= YW'(START_Y);
      cnt_q   <= '0;
      bump_q  <= 1'b0;
      win_q   <= 1'b0;
    end else begin
      bump_q <= 1'b0;
      if (state_q == PLAY && mv) begin
        if (blocked) begin
          bump_q <= 1'b1;
        end else begin
          pos_x_q <= XW'(tx);
          pos_y_q <= YW'(ty);
          if (cnt_q != '1) cnt_q <= cnt_q + COUNT_W'(1);
          if (at_goal) begin
            state_q <= WIN;
            win_q   <= 1'b1;
          end
        end
      end
    end
  end

  logic [SW-1:0] sdiv_q;
  logic [YW-1:0] r_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sdiv_q <= '0;
      r_q    <= '0;
    end else if (sdiv_q == SW'(SCAN_DIV - 1)) begin
      sdiv_q <= '0;
      r_q    <= (r_q == YW'(GRID_H - 1)) ? '0 : r_q + YW'(1);
    end else begin
      sdiv_q <= sdiv_q + SW'(1);
    end
  end

  always_comb begin
    row = '0;
    row[r_q] = 1'b1;
    col = '0;
    for (int c = 0; c < GRID_W; c++)
      col[c] = WALL_MAP[int'(r_q)*GRID_W + c] |
        (pos_x_q == XW'(c) && pos_y_q == r_q);
    if (win_q) col = '1;
  end

  assign pos_x      = pos_x_q;
  assign pos_y      = pos_y_q;
  assign move_count = cnt_q;
  assign bump       = bump_q;
  assign win        = win_q;
endmodule

// File: tb/tb_maze_nav_engine.sv
// tb_maze_nav_engine: scoreboard bench for maze_nav_engine
// (8x8, debounce 2, scan 4, wall at (1,7)).
module tb_maze_nav_engine;
  localparam int D  = 2;
  localparam int SD = 4;
  localparam logic [63:0] WALL = 64'd1 << 57;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic btnTop = 1'b0, btnBottom = 1'b0;
  logic btnLeft = 1'b0, btnRight = 1'b0;
  logic restart = 1'b0;
  logic [2:0] pos_x, pos_y;
  logic [7:0] move_count, row, col;
  logic bump, win;

  maze_nav_engine #(
    .GRID_W(8), .GRID_H(8), .WALL_MAP(WALL),
    .DEBOUNCE_CYCLES(D), .SCAN_DIV(SD), .COUNT_W(8)
  ) dut (
    .clk(clk), .reset(reset),
    .btnTop(btnTop), .btnBottom(btnBottom),
    .btnLeft(btnLeft), .btnRight(btnRight),
    .restart(restart),
    .pos_x(pos_x), .pos_y(pos_y),
    .move_count(move_count), .bump(bump), .win(win),
    .row(row), .col(col)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct {
    int x; int y; int cnt; bit bmp; bit w;
  } exp_t;
  exp_t sb[$];

  int mx = 0, my = 7, mcnt = 0;
  bit mwin = 1'b0;

  function automatic void model_press(input logic [3:0] b,
                                      output exp_t e);
    int tx, ty;
    bit mvd;
    tx = mx; ty = my; mvd = 1'b1;
    if (b[3])      ty--;
    else if (b[2]) ty++;
    else if (b[1]) tx--;
    else if (b[0]) tx++;
    else           mvd = 1'b0;
    e.bmp = 1'b0;
    if (mvd && !mwin) begin
      if (tx < 0 || tx > 7 || ty < 0 || ty > 7 || WALL[ty*8+tx])
        e.bmp = 1'b1;
      else begin
        mx = tx; my = ty;
        if (mcnt < 255) mcnt++;
        if (mx == 7 && my == 0) mwin = 1'b1;
      end
    end
    e.x = mx; e.y = my; e.cnt = mcnt; e.w = mwin;
  endfunction

  function automatic logic [7:0] exp_col(input int r);
    logic [7:0] c;
    for (int i = 0; i < 8; i++)
      c[i] = WALL[r*8+i] | (mx == i && my == r);
    if (mwin) c = 8'hFF;
    return c;
  endfunction

  task automatic check_out(input exp_t e, input string tag);
    chk({tag, "_x"}, pos_x, e.x);
    chk({tag, "_y"}, pos_y, e.y);
    chk({tag, "_cnt"}, move_count, e.cnt);
    chk({tag, "_bump"}, bump, e.bmp);
    chk({tag, "_win"}, win, e.w);
  endtask

  task automatic set_btn(input logic [3:0] b);
    {btnTop, btnBottom, btnLeft, btnRight} = b;
  endtask

  task automatic press(input logic [3:0] b, input int hold,
                       input string tag);
    exp_t e;
    int ox, oy, oc;
    ox = mx; oy = my; oc = mcnt;
    @(posedge clk); #1;
    set_btn(b);
    model_press(b, e);
    sb.push_back(e);
    repeat (D + 2) @(posedge clk);
    #1;
    chk({tag, "_lat_x"}, pos_x, ox);
    chk({tag, "_lat_y"}, pos_y, oy);
    chk({tag, "_lat_cnt"}, move_count, oc);
    @(posedge clk); #1;
    e = sb.pop_front();
    check_out(e, tag);
    @(posedge clk); #1;
    chk({tag, "_bump1"}, bump, 0);
    repeat (hold - (D + 4)) @(posedge clk);
    #1;
    set_btn(4'b0);
    repeat (4) @(posedge clk);
    #1;
    chk({tag, "_hold_x"}, pos_x, e.x);
    chk({tag, "_hold_y"}, pos_y, e.y);
    chk({tag, "_hold_cnt"}, move_count, e.cnt);
  endtask

  task automatic do_restart();
    exp_t e;
    @(posedge clk); #1;
    restart = 1'b1;
    mx = 0; my = 7; mcnt = 0; mwin = 1'b0;
    e.x = 0; e.y = 7; e.cnt = 0; e.bmp = 1'b0; e.w = 1'b0;
    sb.push_back(e);
    @(posedge clk); #1;
    restart = 1'b0;
    e = sb.pop_front();
    check_out(e, "restart");
  endtask

  initial begin
    exp_t e;
    repeat (3) @(posedge clk);
    #1;
    e.x = 0; e.y = 7; e.cnt = 0; e.bmp = 1'b0; e.w = 1'b0;
    check_out(e, "rst");
    chk("rst_row", row, 8'h01);
    chk("rst_col", col, exp_col(0));
    @(posedge clk); #1;
    reset = 1'b1;
    for (int k = 1; k <= 36; k++) begin
      @(posedge clk); #1;
      chk("scan_row", row, 8'h01 << ((k / SD) % 8));
      chk("scan_col", col, exp_col((k / SD) % 8));
    end

    // reset lands mid-debounce with the button still held
    @(posedge clk); #1;
    set_btn(4'b1000);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("midrst_y", pos_y, 7);
    chk("midrst_bump", bump, 0);
    @(posedge clk);
    @(posedge clk); #1;
    reset = 1'b1;
    model_press(4'b1000, e);
    sb.push_back(e);
    repeat (D + 2) @(posedge clk);
    #1;
    chk("midrst_lat_y", pos_y, 7);
    chk("midrst_lat_cnt", move_count, 0);
    @(posedge clk); #1;
    e = sb.pop_front();
    check_out(e, "midrst");
    set_btn(4'b0);
    repeat (4) @(posedge clk);
    do_restart();

    press(4'b1000, 20, "top1");
    press(4'b1000, 8, "top2");
    do_restart();
    press(4'b0010, 8, "left_edge");
    press(4'b0001, 8, "right_wall");
    press(4'b1001, 8, "top_right");

    @(posedge clk); #1;
    btnTop = 1'b1;
    @(posedge clk); #1;
    btnTop = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("glitch_y", pos_y, my);
    chk("glitch_cnt", move_count, mcnt);
    chk("glitch_bump", bump, 0);

    do_restart();
    for (int i = 0; i < 7; i++) press(4'b1000, 7, "walk_up");
    for (int i = 0; i < 7; i++) press(4'b0001, 7, "walk_right");
    chk("win_lvl", win, 1);
    chk("win_col", col, 8'hFF);
    press(4'b0100, 8, "win_ign");
    do_restart();
    chk("post_col", col, exp_col(int'($clog2(int'(row)))));

    // restart coincides with a registered press pulse
    @(posedge clk); #1;
    set_btn(4'b1000);
    repeat (D + 2) @(posedge clk);
    #1;
    restart = 1'b1;
    @(posedge clk); #1;
    restart = 1'b0;
    chk("rs_pri_y", pos_y, 7);
    chk("rs_pri_cnt", move_count, 0);
    chk("rs_pri_bump", bump, 0);
    @(posedge clk); #1;
    chk("rs_pri_y2", pos_y, 7);
    chk("rs_pri_bump2", bump, 0);
    set_btn(4'b0);
    repeat (4) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/maze_nav_engine.md
# maze_nav_engine

Parametrised maze-navigation core for the FPGA board game: conditions the four direction buttons, moves a player marker over a GRID_W × GRID_H maze with a compile-time wall map, and detects arrival at the goal. It drives the row/column LED matrix directly and exposes position, move count and status to the top level. It supersedes the fixed 8×8, 2-bit-state game controller.

## Interface
- GRID_W, 8, grid columns (2..16)
- GRID_H, 8, grid rows (2..16)
- WALL_MAP, 0, GRID_W*GRID_H bits; bit y*GRID_W+x = 1 marks a wall cell; start/goal cells must be 0
- START_X, 0 / START_Y, GRID_H-1, reset/restart position
- GOAL_X, GRID_W-1 / GOAL_Y, 0, goal cell
- DEBOUNCE_CYCLES, 16, stable-high cycles for a press (≥1)
- SCAN_DIV, 1024, clocks per display row (≥1)
- COUNT_W, 8, move counter width
- clk  in  1  system clock; one clock domain
- reset  in  1  asynchronous, active-low; clears all state
- btnTop, btnBottom, btnLeft, btnRight  in  1 each  raw asynchronous buttons, active-high
- restart  in  1  synchronous, active-high; return to start
- pos_x  out  $clog2(GRID_W)  player column
- pos_y  out  $clog2(GRID_H)  player row (0 = top)
- move_count  out  COUNT_W  successful moves, saturating
- bump  out  1  one-cycle pulse on a blocked move
- win  out  1  level, high in WIN state
- row  out  GRID_H  one-hot active-high row strobe
- col  out  GRID_W  active-high column data for strobed row

## Operation
- Per button: 2-FF synchroniser, then counter. Counter clears while synced level is low; increments while high, saturating at DEBOUNCE_CYCLES. Registered press pulse is high for exactly the one cycle after the counter reaches DEBOUNCE_CYCLES; no further pulse until the level returns low.
- Simultaneous pulses in one cycle: priority Top > Bottom > Left > Right; others discarded.
- Direction: Top y−1, Bottom y+1, Left x−1, Right x+1.
- FSM: PLAY, WIN. Reset → PLAY, pos = (START_X, START_Y), move_count = 0.
- PLAY, press: target off-grid or wall bit set → pos unchanged, count unchanged, bump = 1 next cycle. Otherwise pos updated, move_count+1 (holds at 2^COUNT_W−1). New pos = goal → WIN on the same edge.
- WIN: win = 1. Presses ignored, no bump.
- restart (any state) → PLAY, start position, count 0, bump 0. Has priority over a same-cycle press, which is discarded.
- Display: scan index r advances every SCAN_DIV clocks, wrapping GRID_H−1 → 0. row[r] = 1, all other bits 0. In PLAY, col[c] = wall(r,c) | (pos == (c,r)). In WIN, col = all ones.
- Reset asserted mid-debounce or mid-scan clears counters and pulses immediately. A button held through reset release must be re-qualified from count 0.

## Timing
- Reset values: pos = (START_X, START_Y), move_count = 0, bump = 0, win = 0, row = one-hot bit 0, col = row-0 pattern.
- Press latency: number the first rising edge that samples the raw button high as edge 1. The press pulse registers at edge DEBOUNCE_CYCLES+2. pos/move_count/bump/win update at edge DEBOUNCE_CYCLES+3.
- col follows pos combinationally from the registered state, with no extra latency.
- restart takes effect at the first edge sampling it high.

## Test plan
- Defaults, DEBOUNCE_CYCLES=2, WALL_MAP=0. Reset low 3 cycles, then release → pos (0,7), move_count 0, win 0, bump 0, row 8'b0000_0001.
- btnTop held 20 cycles → exactly one move: pos (0,6), move_count 1, update at edge 5. Release, press again → (0,5), count 2.
- At (0,7), btnLeft pulse → bump high exactly 1 cycle, pos (0,7), count 0. Repeat with WALL_MAP bit 57 set (cell (1,7)) and btnRight → bump, no move.
- btnTop and btnRight rise on the same edge → pos (0,6) only, count 1. 2-cycle glitch with DEBOUNCE_CYCLES=4 → no move.
- 7×Top then 7×Right → pos (7,0), win 1 after the 14th move, count 14. Further presses → no change. restart → (0,7), count 0, win 0.
- Reset asserted at edge 3 of a debounce, button held → no move until re-qualified: move at edge DEBOUNCE_CYCLES+3 after reset release. SCAN_DIV=4 → row walks bit 0..7 every 4 clocks and wraps to bit 0.
